// File: rtl/shumaguan_pkg.sv
// Shared glyph constants and sizing helper for the multiplexed seven-segment scanner.
// Glyphs are active-high with segment a on bit 0.
package shumaguan_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // clog2 floored at 1 so a single-value counter still has a real bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex2seg.sv
// Combinational nibble to seven-segment decoder, active-high, a = bit 0.
// Letters b and d use their lowercase glyphs.
module hex2seg
    import shumaguan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/shumaguan_multi.sv
// Parametrised multiplexed seven-segment scanner with dead time, blanking, blink,
// decimal points and frame-coherent capture of the displayed value.
module shumaguan_multi
    import shumaguan_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 50000,
    parameter int DEAD_CYCLES  = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   passvalue,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     wei,
    output logic [6:0]            duan,
    output logic                  dp
);

    localparam int PRE_W = cnt_width(CLK_DIV);
    localparam int IDX_W = cnt_width(DIGITS);
    localparam int BLK_W = cnt_width(BLINK_FRAMES);

    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [DIGITS-1:0][3:0]  pv_sh_q, pv_sh_d;
    logic [DIGITS-1:0]       en_sh_q, en_sh_d;
    logic [DIGITS-1:0]       blk_sh_q, blk_sh_d;
    logic [DIGITS-1:0]       dp_sh_q, dp_sh_d;
    logic [DIGITS-1:0]       wei_q, wei_d;
    logic [6:0]              duan_q, duan_d;
    logic                    dp_out_q, dp_out_d;

    logic                    tick, frame_start, frame_end, visible;
    logic [3:0]              sel_nib;
    logic                    sel_en, sel_blk, sel_dp;
    logic [6:0]              sel_seg;
    logic [DIGITS-1:0]       wei_act;

    hex2seg u_hex2seg (
        .nibble (sel_nib),
        .seg    (sel_seg)
    );

    always_comb begin
        tick        = (pre_q == PRE_W'(CLK_DIV - 1));
        frame_start = (pre_q == '0) && (idx_q == '0);
        frame_end   = tick && (idx_q == IDX_W'(DIGITS - 1));

        pre_d = tick ? '0 : pre_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        pv_sh_d  = frame_start ? passvalue : pv_sh_q;
        en_sh_d  = frame_start ? digit_en  : en_sh_q;
        blk_sh_d = frame_start ? blink_en  : blk_sh_q;
        dp_sh_d  = frame_start ? dp_in     : dp_sh_q;

        // Blink phase flips on the same edge that wraps the index, so the new
        // phase is already in place for the next frame's first lit cycle.
        blk_cnt_d     = blk_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_end) begin
            if (blk_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                blk_cnt_d     = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end

        sel_nib = 4'h0;
        sel_en  = 1'b0;
        sel_blk = 1'b0;
        sel_dp  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nib = pv_sh_q[i];
                sel_en  = en_sh_q[i];
                sel_blk = blk_sh_q[i];
                sel_dp  = dp_sh_q[i];
            end
        end

        visible = sel_en && !(sel_blk && !blink_phase_q) &&
                  (pre_q >= PRE_W'(DEAD_CYCLES));

        wei_act = '0;
        for (int i = 0; i < DIGITS; i++) begin
            wei_act[i] = visible && (idx_q == IDX_W'(i));
        end

        wei_d    = ACTIVE_LOW ? ~wei_act : wei_act;
        duan_d   = visible ? sel_seg : SEG_BLANK;
        duan_d   = ACTIVE_LOW ? ~duan_d : duan_d;
        dp_out_d = (visible && sel_dp) ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q         <= '0;
            idx_q         <= '0;
            blk_cnt_q     <= '0;
            blink_phase_q <= 1'b1;
            pv_sh_q       <= '0;
            en_sh_q       <= '0;
            blk_sh_q      <= '0;
            dp_sh_q       <= '0;
            wei_q         <= {DIGITS{ACTIVE_LOW}};
            duan_q        <= {7{ACTIVE_LOW}};
            dp_out_q      <= ACTIVE_LOW;
        end else begin
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            blk_cnt_q     <= blk_cnt_d;
            blink_phase_q <= blink_phase_d;
            pv_sh_q       <= pv_sh_d;
            en_sh_q       <= en_sh_d;
            blk_sh_q      <= blk_sh_d;
            dp_sh_q       <= dp_sh_d;
            wei_q         <= wei_d;
            duan_q        <= duan_d;
            dp_out_q      <= dp_out_d;
        end
    end

    assign wei  = wei_q;
    assign duan = duan_q;
    assign dp   = dp_out_q;

endmodule

// File: tb/tb_shumaguan_multi.sv
// Scoreboard bench: a 4-digit active-low scanner and a 1-digit active-high scanner
// are driven together and compared against a cycle-arithmetic display model.
module tb_shumaguan_multi;

    localparam int CLK = 4;
    localparam int DEAD = 1;
    localparam int BF = 2;

    typedef struct {
        int         due;
        logic [3:0] wei;
        logic [6:0] duan;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pv = 16'h0;
    logic [3:0]  en = 4'h0, bl = 4'h0, dpi = 4'h0;
    logic [3:0]  wei4;
    logic [6:0]  duan4, duan1;
    logic        dp4, dp1;
    logic [0:0]  wei1;

    int   cyc = 0;
    int   c = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q4[$];
    exp_t q1[$];

    logic [15:0] sh_pv4, sh_pv1;
    logic [3:0]  sh_en4, sh_bl4, sh_dp4, sh_en1, sh_bl1, sh_dp1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shumaguan_multi #(.DIGITS(4), .CLK_DIV(CLK), .DEAD_CYCLES(DEAD),
                      .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)) dut4 (
        .clk(clk), .rst(rst), .passvalue(pv), .digit_en(en), .blink_en(bl),
        .dp_in(dpi), .wei(wei4), .duan(duan4), .dp(dp4)
    );

    shumaguan_multi #(.DIGITS(1), .CLK_DIV(CLK), .DEAD_CYCLES(DEAD),
                      .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b0)) dut1 (
        .clk(clk), .rst(rst), .passvalue(pv[3:0]), .digit_en(en[0:0]), .blink_en(bl[0:0]),
        .dp_in(dpi[0:0]), .wei(wei1), .duan(duan1), .dp(dp1)
    );

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    // Display expected for cycle c counted from the first cycle after reset.
    function automatic exp_t model(input int cc, input int nd, input bit al, input bit force_off,
                                   input logic [3:0] e, input logic [3:0] b,
                                   input logic [3:0] d, input logic [15:0] v);
        exp_t r;
        int slot, pos, frame;
        bit vis;
        logic [3:0] mask;
        slot  = (cc / CLK) % nd;
        pos   = cc % CLK;
        frame = cc / (nd * CLK);
        vis   = !force_off && e[slot] && !(b[slot] && ((frame / BF) % 2 == 1)) && (pos >= DEAD);
        mask  = 4'((1 << nd) - 1);
        r.due  = 0;
        r.wei  = vis ? 4'(1 << slot) : 4'h0;
        r.duan = vis ? glyph(v[slot*4 +: 4]) : 7'h00;
        r.dp   = vis && d[slot];
        if (al) begin
            r.wei  = ~r.wei & mask;
            r.duan = ~r.duan;
            r.dp   = ~r.dp;
        end
        return r;
    endfunction

    task automatic step();
        exp_t e4, e1;
        if (rst) begin
            e4 = model(0, 4, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0);
            e1 = model(0, 1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0);
            c = 0;
        end else begin
            e4 = model(c, 4, 1'b1, 1'b0, sh_en4, sh_bl4, sh_dp4, sh_pv4);
            e1 = model(c, 1, 1'b0, 1'b0, sh_en1, sh_bl1, sh_dp1, sh_pv1);
            if (c % (4 * CLK) == 0) begin
                sh_pv4 = pv; sh_en4 = en; sh_bl4 = bl; sh_dp4 = dpi;
            end
            if (c % CLK == 0) begin
                sh_pv1 = {12'h0, pv[3:0]}; sh_en1 = {3'b0, en[0]};
                sh_bl1 = {3'b0, bl[0]};    sh_dp1 = {3'b0, dpi[0]};
            end
            c++;
        end
        e4.due = cyc + 1;
        e1.due = cyc + 1;
        q4.push_back(e4);
        q1.push_back(e1);
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q4.size() > 0 && q4[0].due <= cyc) begin
            e = q4.pop_front();
            vectors++;
            if (wei4 !== e.wei || duan4 !== e.duan || dp4 !== e.dp) begin
                miscompares++;
                $display("FAIL dut4 cyc=%0d got wei=%b duan=%b dp=%b expected wei=%b duan=%b dp=%b",
                         cyc, wei4, duan4, dp4, e.wei, e.duan, e.dp);
            end
        end
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            vectors++;
            if (wei1 !== e.wei[0:0] || duan1 !== e.duan || dp1 !== e.dp) begin
                miscompares++;
                $display("FAIL dut1 cyc=%0d got wei=%b duan=%b dp=%b expected wei=%b duan=%b dp=%b",
                         cyc, wei1, duan1, dp1, e.wei[0], e.duan, e.dp);
            end
        end
    end

    initial begin
        sh_pv4 = '0; sh_en4 = '0; sh_bl4 = '0; sh_dp4 = '0;
        sh_pv1 = '0; sh_en1 = '0; sh_bl1 = '0; sh_dp1 = '0;
        @(posedge clk);
        #2;
        run(3);                                        // reset state
        rst = 1'b0;
        pv = 16'h1874; en = 4'hF; bl = 4'h0; dpi = 4'h0;
        run(32);                                       // basic scan, two frames
        run(10);                                       // digit 2, second lit cycle
        pv = 16'hFFFF;
        run(22);                                       // coherence through next frame
        en = 4'b1011; dpi = 4'b0001;
        run(32);
        en = 4'hF; dpi = 4'h0; bl = 4'b0001;
        run(96);                                       // six frames of blink
        bl = 4'h0;
        run(9);                                        // reset during digit 2
        pv = 16'h2A5A;
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(48);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) begin
                pv = 16'($urandom); en = 4'($urandom); bl = 4'($urandom); dpi = 4'($urandom);
            end
            rst = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0;
        run(2);
        repeat (3) @(negedge clk);
        if (q4.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d expected 0", q4.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
